// File: rtl/register_bank_reader.sv
// Byte register bank with two registered read ports (operand fetch) and a
// valid/ready debug dump sequencer that streams every register out in order.
module register_bank_reader #(
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [7:0]        write_data,
  input  logic              rd_a_en,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [7:0]        rd_a_data,
  output logic              rd_a_valid,
  input  logic              rd_b_en,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [7:0]        rd_b_data,
  output logic              rd_b_valid,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [7:0]        dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_e;

  logic [7:0]        regs_q [DEPTH];
  logic              wr_eff;

  logic [7:0]        rd_a_data_q, rd_a_data_d;
  logic              rd_a_valid_q;
  logic [7:0]        rd_b_data_q, rd_b_data_d;
  logic              rd_b_valid_q;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [7:0]        beat_q, beat_d;

  assign wr_eff = write_enable && !(ZERO_REG && (write_addr == '0));

  // Value a read at the coming edge must return: hard zero, same-edge write
  // bypass, or stored contents.
  function automatic logic [7:0] read_val(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG && (addr == '0)) return 8'h00;
    if (wr_eff && (write_addr == addr)) return write_data;
    return regs_q[addr];
  endfunction

  // NOTE: this bank is a handful of flops, not an SRAM macro, so resetting the
  // whole array is cheap and gives a known readback after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else if (wr_eff) begin
      regs_q[write_addr] <= write_data;
    end
  end

  always_comb begin
    rd_a_data_d = rd_a_en ? read_val(rd_a_addr) : rd_a_data_q;
    rd_b_data_d = rd_b_en ? read_val(rd_b_addr) : rd_b_data_q;
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // independent of the order in which always_ff blocks are evaluated.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_a_data_q  <= 8'h00;
      rd_a_valid_q <= 1'b0;
      rd_b_data_q  <= 8'h00;
      rd_b_valid_q <= 1'b0;
    end else begin
      rd_a_data_q  <= rd_a_data_d;
      rd_a_valid_q <= rd_a_en;
      rd_b_data_q  <= rd_b_data_d;
      rd_b_valid_q <= rd_b_en;
    end
  end

  assign rd_a_data  = rd_a_data_q;
  assign rd_a_valid = rd_a_valid_q;
  assign rd_b_data  = rd_b_data_q;
  assign rd_b_valid = rd_b_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      beat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  assign ptr_inc = ptr_q + ADDR_W'(1);

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SEND;
          ptr_d   = '0;
          beat_d  = read_val('0);
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        // Next beat is captured on the same edge as the transfer, so beats
        // stream back-to-back while the consumer keeps ready high.
        if (dump_ready) begin
          if (ptr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            ptr_d  = ptr_inc;
            beat_d = read_val(ptr_inc);
          end
        end
      end
      DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_addr = ptr_q;
  assign dump_data = beat_q;

endmodule

// File: tb/tb_register_bank_reader.sv
// Scoreboard bench: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus;
// a behavioural model predicts each response, a negedge monitor compares.
module tb_register_bank_reader;

  typedef struct { bit v; logic [7:0] d0; logic [7:0] d1; } rd_exp_t;
  typedef struct { logic [2:0] a; logic [7:0] d0; logic [7:0] d1; } beat_exp_t;
  typedef struct { bit v; bit b; bit d; } ctl_exp_t;

  logic       clock = 1'b0;
  logic       reset, we, ae, be, ds, dr;
  logic [2:0] wa, aa, ba;
  logic [7:0] wd;

  logic [7:0] a_data0, b_data0, dd0, a_data1, b_data1, dd1;
  logic       a_val0, b_val0, dv0, dbusy0, ddone0;
  logic       a_val1, b_val1, dv1, dbusy1, ddone1;
  logic [2:0] da0, da1;

  int n_checks = 0;
  int n_fail   = 0;

  rd_exp_t   qa[$], qb[$];
  beat_exp_t qbeat[$];
  ctl_exp_t  qctl[$];

  // Model: array contents as seen by each instance, dump progress, held read data.
  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];
  int         m_state;  // 0 idle, 1 streaming, 2 done pulse
  int         m_ptr;
  logic [7:0] ea0, ea1, eb0, eb1;

  always #5 clock = ~clock;

  register_bank_reader #(.ADDR_W(3), .ZERO_REG(1'b0)) dut0 (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa), .write_data(wd),
    .rd_a_en(ae), .rd_a_addr(aa), .rd_a_data(a_data0), .rd_a_valid(a_val0),
    .rd_b_en(be), .rd_b_addr(ba), .rd_b_data(b_data0), .rd_b_valid(b_val0),
    .dump_start(ds), .dump_ready(dr), .dump_valid(dv0), .dump_addr(da0),
    .dump_data(dd0), .dump_busy(dbusy0), .dump_done(ddone0));

  register_bank_reader #(.ADDR_W(3), .ZERO_REG(1'b1)) dut1 (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa), .write_data(wd),
    .rd_a_en(ae), .rd_a_addr(aa), .rd_a_data(a_data1), .rd_a_valid(a_val1),
    .rd_b_en(be), .rd_b_addr(ba), .rd_b_data(b_data1), .rd_b_valid(b_val1),
    .dump_start(ds), .dump_ready(dr), .dump_valid(dv1), .dump_addr(da1),
    .dump_data(dd1), .dump_busy(dbusy1), .dump_done(ddone1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // What a read of address a returns for the coming edge (z selects zero-reg instance).
  function automatic logic [7:0] peek(input bit z, input int a);
    if (z && a == 0) return 8'h00;
    if (we && !(z && wa == 3'd0) && int'(wa) == a) return wd;
    return z ? mem1[a] : mem0[a];
  endfunction

  // Predict the effect of the coming edge, queue expectations, then take the edge.
  task automatic tick();
    rd_exp_t ra, rb;
    ctl_exp_t c;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
      ea0 = 8'h00; ea1 = 8'h00; eb0 = 8'h00; eb1 = 8'h00;
      m_state = 0; m_ptr = 0;
    end else begin
      if (ae) begin ea0 = peek(0, int'(aa)); ea1 = peek(1, int'(aa)); end
      if (be) begin eb0 = peek(0, int'(ba)); eb1 = peek(1, int'(ba)); end
      case (m_state)
        0: if (ds) begin
             m_state = 1; m_ptr = 0;
             qbeat.push_back('{3'd0, peek(0, 0), peek(1, 0)});
           end
        1: if (dr) begin
             if (m_ptr < 7) begin
               m_ptr++;
               qbeat.push_back('{3'(m_ptr), peek(0, m_ptr), peek(1, m_ptr)});
             end else m_state = 2;
           end
        default: m_state = 0;
      endcase
      if (we) begin
        mem0[wa] = wd;
        if (wa != 3'd0) mem1[wa] = wd;
      end
    end
    ra = '{(!reset && ae), ea0, ea1};
    rb = '{(!reset && be), eb0, eb1};
    qa.push_back(ra);
    qb.push_back(rb);
    c = '{(m_state == 1), (m_state != 0), (m_state == 2)};
    qctl.push_back(c);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; we = 1'b0; wa = 3'd0; wd = 8'h00;
    ae = 1'b0; aa = 3'd0; be = 1'b0; ba = 3'd0; ds = 1'b0; dr = 1'b1;
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    rd_exp_t e;
    ctl_exp_t c;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check("rd_a_valid", {30'd0, a_val1, a_val0}, {30'd0, e.v, e.v});
      check("rd_a_data0", 32'(a_data0), 32'(e.d0));
      check("rd_a_data1", 32'(a_data1), 32'(e.d1));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("rd_b_valid", {30'd0, b_val1, b_val0}, {30'd0, e.v, e.v});
      check("rd_b_data0", 32'(b_data0), 32'(e.d0));
      check("rd_b_data1", 32'(b_data1), 32'(e.d1));
    end
    if (qctl.size() > 0) begin
      c = qctl.pop_front();
      check("dump_ctl0", {29'd0, dv0, dbusy0, ddone0}, {29'd0, c.v, c.b, c.d});
      check("dump_ctl1", {29'd0, dv1, dbusy1, ddone1}, {29'd0, c.v, c.b, c.d});
    end
    if (dv0) begin
      if (qbeat.size() == 0) begin
        check("dump_beat_unexpected", 32'd1, 32'd0);
      end else begin
        check("dump_addr0", 32'(da0), 32'(qbeat[0].a));
        check("dump_data0", 32'(dd0), 32'(qbeat[0].d0));
        check("dump_addr1", 32'(da1), 32'(qbeat[0].a));
        check("dump_data1", 32'(dd1), 32'(qbeat[0].d1));
        // reset shown here applies to the coming edge: the held beat is abandoned
        if (reset) qbeat.delete();
        else if (dr) void'(qbeat.pop_front());
      end
    end else if (reset) begin
      qbeat.delete();
    end
  end

  initial begin
    int guard;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    check("reset_dump_addr", 32'(da0), 32'd0);
    check("reset_dump_data", 32'(dd0), 32'd0);
    check("reset_rd_a_data", 32'(a_data0), 32'd0);
    reset = 1'b0;

    // Fill with random contents, then reset and read everything back as zero.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); wd = 8'($urandom_range(1, 255)); tick();
    end
    idle_inputs(); reset = 1'b1; we = 1'b1; wa = 3'd2; wd = 8'h77; ae = 1'b1; tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      ae = 1'b1; aa = 3'(i); be = 1'b1; ba = 3'(7 - i); tick();
    end
    idle_inputs();

    // Write then read; same-edge bypass on both ports; zero register.
    we = 1'b1; wa = 3'd3; wd = 8'hA5; tick();
    idle_inputs(); ae = 1'b1; aa = 3'd3; tick();
    idle_inputs(); tick();
    we = 1'b1; wa = 3'd5; wd = 8'h3C; ae = 1'b1; aa = 3'd5; be = 1'b1; ba = 3'd5; tick();
    idle_inputs();
    we = 1'b1; wa = 3'd0; wd = 8'hFF; ae = 1'b1; aa = 3'd0; tick();
    idle_inputs(); ae = 1'b1; aa = 3'd0; be = 1'b1; ba = 3'd1; tick();
    idle_inputs(); tick();

    // Dumps: ready high, then ready toggling with writes and ignored restarts.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); wd = 8'(i * 17); tick();
    end
    idle_inputs(); ds = 1'b1; tick();
    ds = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    ds = 1'b1; dr = 1'b0; tick();
    for (int i = 0; i < 24; i++) begin
      ds = (i % 5 == 2);
      dr = i[0];
      we = (i % 3 == 0); wa = 3'($urandom_range(0, 7)); wd = 8'($urandom);
      ae = 1'b1; aa = 3'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    guard = 0;
    while (m_state != 0 && guard < 40) begin tick(); guard++; end
    check("dump2_completes", 32'(m_state), 32'd0);

    // Reset while beat 4 is presented, then a fresh dump restarts at address 0.
    ds = 1'b1; tick(); ds = 1'b0;
    guard = 0;
    while (!(m_state == 1 && m_ptr == 4) && guard < 40) begin tick(); guard++; end
    check("dump_reached_beat4", 32'(m_ptr), 32'd4);
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    ds = 1'b1; tick(); ds = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      we = $urandom_range(0, 1); wa = 3'($urandom); wd = 8'($urandom);
      ae = $urandom_range(0, 1); aa = 3'($urandom);
      be = $urandom_range(0, 1); ba = 3'($urandom);
      ds = ($urandom_range(0, 7) == 0); dr = ($urandom_range(0, 3) != 0);
      tick();
    end

    idle_inputs();
    for (int i = 0; i < 14; i++) tick();
    @(negedge clock);
    #1;
    check("queues_drained", 32'(qa.size() + qb.size() + qctl.size() + qbeat.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
